// File: rtl/adder_result_uart_tx.sv
// ---------------------------------------------------------------------------
// adder_result_uart_tx
//
// Serializes one adder result ({carry, sum}) into a fixed UART 8N1 frame of
// NUM_BYTES = DATA_W/8 + 1 bytes. The sum bytes go out least-significant
// first, then a final byte {7'b0, carry}. Each byte has a start bit (0), 8
// data bits LSB first and a stop bit (1). There is no gap between the bytes
// of a frame. One result is accepted per frame through a valid/ready
// handshake; there is no queue.
//
// Ports:
//   clk_i    in   system clock, rising edge
//   rst_ni   in   asynchronous active-low reset (released synchronously)
//   sum_i    in   [DATA_W-1:0] adder sum
//   carry_i  in   adder carry-out
//   valid_i  in   sum_i/carry_i valid
//   ready_o  out  high while idle; an accept happens when valid_i && ready_o
//   tx_o     out  UART serial line, idle high, driven straight from a flop
//   busy_o   out  frame in progress
//   done_o   out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module adder_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] sum_i,
    input  logic              carry_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int NUM_BYTES = DATA_W / 8 + 1;
    localparam int FRAME_W   = NUM_BYTES * 8;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W    = $clog2(NUM_BYTES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [BAUD_W-1:0]    r_baud, w_baud_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [BYTE_W-1:0]    r_byte, w_byte_nxt;
    logic [FRAME_W-1:0]   r_frame, w_frame_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_done, w_done_nxt;
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic                 w_accept;
    logic                 w_bit_end;

    // Reset asserts immediately and releases on a clock edge, so the whole
    // block leaves reset in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_accept  = valid_i && (r_state == S_IDLE);
    assign w_bit_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_frame_nxt = r_frame;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_frame_nxt = {{(FRAME_W - DATA_W - 1){1'b0}}, carry_i, sum_i};
                    w_byte_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_byte == BYTE_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // The byte on the wire is always the low byte of the
                        // frame register.
                        w_state_nxt = S_START;
                        w_byte_nxt  = r_byte + 1'b1;
                        w_frame_nxt = r_frame >> 8;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The line level is computed from the next state so that tx_o comes
        // out of a flop with no extra cycle of latency.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_frame_nxt[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_frame <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_frame <= w_frame_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign busy_o  = (r_state != S_IDLE);
    assign tx_o    = r_tx;
    assign done_o  = r_done;

endmodule

// File: tb/tb_adder_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_adder_result_uart_tx
//
// Directed bench for adder_result_uart_tx with CLKS_PER_BIT=4, DATA_W=64.
// A frame is 9 bytes * 10 bits * 4 clocks = 360 line cycles. Outputs are
// sampled on the falling edge; cycle 0 is the first cycle after the accept
// edge. The UART receiver samples each bit in its middle (clock 2 of 4).
// ---------------------------------------------------------------------------
module tb_adder_result_uart_tx;

    localparam int CPB    = 4;
    localparam int DW     = 64;
    localparam int NBYTES = DW / 8 + 1;
    localparam int FRAME_CYCLES = NBYTES * 10 * CPB;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] sum;
    logic          carry;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    adder_result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sum_i  (sum),
        .carry_i(carry),
        .valid_i(valid),
        .ready_o(ready),
        .tx_o   (tx),
        .busy_o (busy),
        .done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one result at a falling edge and release valid after the
    // accepting rising edge.
    task automatic accept(input logic [DW-1:0] s, input logic c);
        @(negedge clk);
        check("ready_before_accept", 72'(ready), 72'(1'b1));
        sum   = s;
        carry = c;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Record one frame starting at cycle 0 and decode it. Optionally pulses
    // valid_i with a different result in the middle of the frame.
    task automatic capture(input bit pulse_mid, output logic [71:0] data,
                           output int frame_err, output int busy_err,
                           output int done_err, output int ready_err);
        int bitpos;
        int k;
        int b;
        data      = '0;
        frame_err = 0;
        busy_err  = 0;
        done_err  = 0;
        ready_err = 0;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            @(negedge clk);
            if (busy !== 1'b1)  busy_err++;
            if (done !== 1'b0)  done_err++;
            if (ready !== 1'b0) ready_err++;
            if ((c % CPB) == CPB / 2) begin
                bitpos = c / CPB;
                k = bitpos % 10;
                b = bitpos / 10;
                if (k == 0) begin
                    if (tx !== 1'b0) frame_err++;
                end else if (k == 9) begin
                    if (tx !== 1'b1) frame_err++;
                end else begin
                    data[b*8 + k - 1] = tx;
                end
            end
            if (pulse_mid && c == 100) begin
                sum   = 64'h1;
                carry = 1'b1;
                valid = 1'b1;
            end
            if (pulse_mid && c == 101) begin
                valid = 1'b0;
            end
        end
    endtask

    logic [71:0] got;
    int fe, be, de, re;
    int extra;

    initial begin
        rst_n = 1'b0;
        sum   = '0;
        carry = 1'b0;
        valid = 1'b0;

        // Test 1: reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", 72'({tx, ready, busy, done}), 72'(4'b1100));
            valid = ~valid;
            sum   = ~sum;
            carry = ~carry;
        end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        check("after_release_outputs", 72'({tx, ready, busy, done}), 72'(4'b1100));

        // Test 2: main frame with carry set
        accept(64'h0123456789ABCDEF, 1'b1);
        capture(1'b0, got, fe, be, de, re);
        check("t2_data", got, {8'h01, 64'h0123456789ABCDEF});
        check("t2_framing", 72'(fe), 72'(0));
        check("t2_busy_during_frame", 72'(be), 72'(0));
        check("t2_done_during_frame", 72'(de), 72'(0));
        check("t2_ready_during_frame", 72'(re), 72'(0));
        @(negedge clk);
        check("t2_done_cycle", 72'({tx, ready, busy, done}), 72'(4'b1101));
        @(negedge clk);
        check("t2_after_done", 72'({tx, ready, busy, done}), 72'(4'b1100));

        // Test 3: all-ones sum, carry clear
        accept(64'hFFFFFFFFFFFFFFFF, 1'b0);
        capture(1'b0, got, fe, be, de, re);
        check("t3_data", got, {8'h00, 64'hFFFFFFFFFFFFFFFF});
        check("t3_framing", 72'(fe), 72'(0));
        @(negedge clk);
        check("t3_done_cycle", 72'(done), 72'(1'b1));

        // Test 4: valid pulse during a frame is ignored
        accept(64'h00000000000000C3, 1'b0);
        capture(1'b1, got, fe, be, de, re);
        check("t4_data", got, {8'h00, 64'h00000000000000C3});
        check("t4_framing", 72'(fe), 72'(0));
        check("t4_ready_low", 72'(re), 72'(0));
        @(negedge clk);
        check("t4_done_cycle", 72'(done), 72'(1'b1));
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) extra++;
        end
        check("t4_no_second_frame", 72'(extra), 72'(0));

        // Test 5: valid held high, back-to-back results
        @(negedge clk);
        sum   = 64'h5;
        carry = 1'b0;
        valid = 1'b1;
        @(posedge clk);
        #1 sum = 64'hA;
        capture(1'b0, got, fe, be, de, re);
        check("t5_first_data", got, {8'h00, 64'h5});
        check("t5_first_framing", 72'(fe), 72'(0));
        @(negedge clk);
        check("t5_gap_cycle", 72'({tx, ready, busy, done}), 72'(4'b1101));
        @(posedge clk);
        #1 valid = 1'b0;
        capture(1'b0, got, fe, be, de, re);
        check("t5_second_data", got, {8'h00, 64'hA});
        check("t5_second_framing", 72'(fe), 72'(0));
        check("t5_second_busy", 72'(be), 72'(0));
        @(negedge clk);
        check("t5_second_done", 72'(done), 72'(1'b1));

        // Test 6: asynchronous reset in the start bit of byte 3
        @(negedge clk);
        accept(64'h0123456789ABCDEF, 1'b1);
        for (int c = 0; c <= 3 * 10 * CPB + CPB / 2; c++) begin
            @(negedge clk);
        end
        check("t6_line_low_before_reset", 72'({tx, busy}), 72'(2'b01));
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 72'({tx, ready, busy, done}), 72'(4'b1100));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) check("t6_idle_after_release", 72'({tx, ready, busy, done}), 72'(4'b1100));
        end
        accept(64'h2A, 1'b0);
        capture(1'b0, got, fe, be, de, re);
        check("t6_clean_data", got, {8'h00, 64'h2A});
        check("t6_clean_framing", 72'(fe), 72'(0));
        @(negedge clk);
        check("t6_done_cycle", 72'(done), 72'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
